// File: rtl/bit_ram_word_store_arbiter.sv
// Round-robin front-end that serialises word-store requests from several cores
// into single-bit stores (MSB first) on one shared memory write port.
module bit_ram_word_store_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 14,
  parameter int WORD_W    = 17,
  parameter int LEN_W     = 5,
  parameter int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          clear_n,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CORES*WORD_W-1:0]   req_data,
  input  logic [NUM_CORES*LEN_W-1:0]    req_len,
  output logic [NUM_CORES-1:0]          req_ready,
  output logic [NUM_CORES-1:0]          done,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic [ADDR_W-1:0]             ram_address,
  output logic                          ram_datain,
  output logic                          ram_store
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [WORD_W-1:0]      data_q, data_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [ADDR_W-1:0]      ram_address_q, ram_address_d;
  logic                   ram_datain_q, ram_datain_d;
  logic                   ram_store_q, ram_store_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic [NUM_CORES-1:0]   ready_raw;

  // Arbitration temporaries
  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W:0]          scan_sum;
  logic [ID_W-1:0]        scan_idx;
  logic [ADDR_W-1:0]      sel_addr;
  logic [WORD_W-1:0]      sel_data;
  logic [LEN_W-1:0]       sel_len;
  logic [LEN_W-1:0]       eff_len;
  logic [ID_W-1:0]        next_ptr;

  // First valid request scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
  // NOTE: combinational temporaries use blocking '=' so later loop iterations see earlier results.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_CORES)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_CORES);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    sel_data = req_data[grant_idx*WORD_W +: WORD_W];
    sel_len  = req_len[grant_idx*LEN_W +: LEN_W];
    // A zero or oversized length means a full word.
    if (sel_len == '0 || sel_len > LEN_W'(WORD_W)) begin
      eff_len = LEN_W'(WORD_W);
    end else begin
      eff_len = sel_len;
    end
    if (grant_idx == ID_W'(NUM_CORES - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + ID_W'(1);
    end
  end

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    data_d        = data_q;
    rem_d         = rem_q;
    ram_address_d = ram_address_q;
    ram_datain_d  = ram_datain_q;
    ram_store_d   = 1'b0;
    done_d        = '0;
    ready_raw     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          ready_raw[grant_idx] = 1'b1;
          grant_d              = grant_idx;
          rr_ptr_d             = next_ptr;
          ram_address_d        = sel_addr;
          ram_datain_d         = sel_data[WORD_W-1];
          data_d               = sel_data << 1;
          ram_store_d          = 1'b1;
          rem_d                = eff_len - LEN_W'(1);
          done_d[grant_idx]    = (eff_len == LEN_W'(1));
          state_d              = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // rem_q counts the bits still to follow the one on the port now.
        if (rem_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ram_store_d     = 1'b1;
          ram_address_d   = ram_address_q + ADDR_W'(1);
          ram_datain_d    = data_q[WORD_W-1];
          data_d          = data_q << 1;
          rem_d           = rem_q - LEN_W'(1);
          done_d[grant_q] = (rem_q == LEN_W'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: asynchronous active-low reset; all state uses non-blocking '<=' only.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      data_q        <= '0;
      rem_q         <= '0;
      ram_address_q <= '0;
      ram_datain_q  <= 1'b0;
      ram_store_q   <= 1'b0;
      done_q        <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      data_q        <= data_d;
      rem_q         <= rem_d;
      ram_address_q <= ram_address_d;
      ram_datain_q  <= ram_datain_d;
      ram_store_q   <= ram_store_d;
      done_q        <= done_d;
    end
  end

  // The accept pulse is combinational, so it is masked while reset is asserted.
  assign req_ready   = ready_raw & {NUM_CORES{clear_n}};
  assign done        = done_q;
  assign busy        = (state_q == ST_WRITE);
  assign grant_id    = grant_q;
  assign ram_address = ram_address_q;
  assign ram_datain  = ram_datain_q;
  assign ram_store   = ram_store_q;

endmodule

// File: tb/tb_bit_ram_word_store_arbiter.sv
// Directed bench for bit_ram_word_store_arbiter with a 1-bit-wide memory model
// fed from the write port and a 17-bit MSB-first fetch window read-back.
module tb_bit_ram_word_store_arbiter;

  localparam int NC = 4;
  localparam int AW = 14;
  localparam int WW = 17;
  localparam int LW = 5;

  logic               clk = 1'b0;
  logic               clear_n;
  logic [NC-1:0]      req_valid;
  logic [NC*AW-1:0]   req_addr;
  logic [NC*WW-1:0]   req_data;
  logic [NC*LW-1:0]   req_len;
  logic [NC-1:0]      req_ready;
  logic [NC-1:0]      done;
  logic               busy;
  logic [1:0]         grant_id;
  logic [AW-1:0]      ram_address;
  logic               ram_datain;
  logic               ram_store;

  bit_ram_word_store_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .WORD_W(WW), .LEN_W(LW)
  ) dut (
    .clk(clk), .clear_n(clear_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_len(req_len),
    .req_ready(req_ready), .done(done), .busy(busy), .grant_id(grant_id),
    .ram_address(ram_address), .ram_datain(ram_datain), .ram_store(ram_store)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_store) mem[ram_address] <= ram_datain;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [AW-1:0] a, input logic [WW-1:0] d,
                         input logic [LW-1:0] l);
    req_addr[c*AW +: AW] = a;
    req_data[c*WW +: WW] = d;
    req_len[c*LW +: LW]  = l;
    req_valid[c]         = 1'b1;
  endtask

  task automatic wait_ready(output int t);
    int i;
    #1;
    i = 0;
    while (req_ready == '0 && i < 40) begin
      step();
      i++;
    end
    check("ready_seen", {31'b0, req_ready != '0}, 1);
    t = cyc;
  endtask

  task automatic expect_store(input string tag, input logic [AW-1:0] a, input logic b,
                              input logic [NC-1:0] dn);
    check({tag, "_store"}, ram_store, 1'b1);
    check({tag, "_addr"}, ram_address, a);
    check({tag, "_bit"}, ram_datain, b);
    check({tag, "_done"}, done, dn);
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, prev_t;
    logic [WW-1:0] dv, win;
    logic [3:0]    exp_bits;
    logic [NC-1:0] exp_r;
    int            order [3];

    clear_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_len   = '0;
    step();
    step();
    check("rst_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_store", ram_store, 0);
    check("rst_grant", grant_id, 0);
    check("rst_addr", ram_address, 0);
    req_valid = 4'b1111;
    #1;
    check("rst_ready_masked", req_ready, 0);
    req_valid = '0;
    clear_n   = 1'b1;
    step();

    // Reset mid-word: five bits land, the rest of the word stays untouched.
    set_req(0, 14'd200, 17'h1_FFFF, 5'd17);
    wait_ready(t);
    check("abort_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      expect_store($sformatf("abort_b%0d", i), 14'(200 + i), 1'b1, 4'b0000);
      step();
    end
    clear_n = 1'b0;
    #1;
    check("abort_store_drop", ram_store, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    step();
    step();
    clear_n = 1'b1;
    step();
    check("abort_no_done", done, 0);
    for (int i = 0; i < WW; i++) begin
      check($sformatf("abort_mem%0d", 200 + i), mem[200 + i], (i < 5) ? 1 : 0);
    end

    // Single request, core 2: bits 1,0,1,0 at 100..103.
    exp_bits = 4'b1010;
    set_req(2, 14'd100, 17'h1_5000, 5'd4);
    wait_ready(t);
    check("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      expect_store($sformatf("single_b%0d", i), 14'(100 + i), exp_bits[3 - i],
                   (i == 3) ? 4'b0100 : 4'b0000);
      check($sformatf("single_lat%0d", i), cyc - t, i + 1);
      check($sformatf("single_gid%0d", i), grant_id, 2);
      check($sformatf("single_busy%0d", i), busy, 1);
      step();
    end
    check("single_idle_store", ram_store, 0);
    check("single_idle_busy", busy, 0);
    check("single_idle_done", done, 0);

    // Round robin from rr_ptr=0 with all four cores requesting.
    do_reset();
    for (int c = 0; c < NC; c++) set_req(c, 14'(1000 + c * 10), 17'h1_8000, 5'd2);
    prev_t = 0;
    for (int k = 0; k < NC; k++) begin
      wait_ready(t);
      check($sformatf("rr_ready%0d", k), req_ready, 1 << k);
      if (k > 0) check($sformatf("rr_gap%0d", k), t - prev_t, 3);
      prev_t = t;
      step();
      req_valid[k] = 1'b0;
      check($sformatf("rr_gid%0d", k), grant_id, k);
      expect_store($sformatf("rr%0d_b0", k), 14'(1000 + k * 10), 1'b1, 4'b0000);
      step();
      expect_store($sformatf("rr%0d_b1", k), 14'(1001 + k * 10), 1'b1, 4'(1 << k));
      step();
    end

    // Fairness: core 0 holds valid, core 3 must still get in between.
    order = '{0, 3, 0};
    set_req(0, 14'd2000, 17'h0_0000, 5'd2);
    set_req(3, 14'd3000, 17'h1_FFFF, 5'd2);
    prev_t = 0;
    for (int j = 0; j < 3; j++) begin
      wait_ready(t);
      exp_r = 4'(1 << order[j]);
      check($sformatf("fair_ready%0d", j), req_ready, exp_r);
      if (j > 0) check($sformatf("fair_gap%0d", j), t - prev_t, 3);
      prev_t = t;
      step();
      if (j >= 1) req_valid[order[j]] = 1'b0;
      step();
      check($sformatf("fair_done%0d", j), done, exp_r);
      step();
    end
    check("fair_idle_ready", req_ready, 0);

    // Address wrap and length clamp: len 0 means 17 bits.
    dv = 17'h1_2345;
    set_req(1, 14'd16382, dv, 5'd0);
    wait_ready(t);
    check("wrap_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    for (int i = 0; i < WW; i++) begin
      expect_store($sformatf("wrap_b%0d", i), 14'(16382 + i), dv[WW - 1 - i],
                   (i == WW - 1) ? 4'b0010 : 4'b0000);
      step();
    end
    check("wrap_end_store", ram_store, 0);

    // Full word write then MSB-first window read-back.
    set_req(0, 14'd0, 17'h0_ABCD, 5'd17);
    wait_ready(t);
    check("mem_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    req_data  = '0;
    repeat (WW) step();
    for (int i = 0; i < WW; i++) win[WW - 1 - i] = mem[i];
    check("mem_window", win, 17'h0_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
